// File: rtl/arith_fsign_share_pkg.sv
// rtl/arith_fsign_share_pkg.sv - shared types, constants and helpers for the FP sign-share block
// Purpose: op encoding, canonical NaN values, IEEE-754 field widths and a NaN detector
//          used by arith_fsign_share.
// Ports:   none (package).
package arith_fsign_pkg;

   typedef enum logic [1:0] {
      OP_NEG  = 2'b00,
      OP_ABS  = 2'b01,
      OP_PASS = 2'b10,
      OP_RSVD = 2'b11
   } fsign_op_e;

   localparam logic [31:0] CANON_NAN_32 = 32'h7FC0_0000;
   localparam logic [63:0] CANON_NAN_64 = 64'h7FF8_0000_0000_0000;

   localparam int EXP_W_32  = 8;
   localparam int MANT_W_32 = 23;
   localparam int EXP_W_64  = 11;
   localparam int MANT_W_64 = 52;

   // Operand is passed zero-extended to 64 bits; is64 selects which field layout to decode.
   function automatic logic is_nan(input logic [63:0] v, input logic is64);
      if (is64) begin
         return (&v[MANT_W_64 +: EXP_W_64]) && (|v[MANT_W_64-1:0]);
      end
      return (&v[MANT_W_32 +: EXP_W_32]) && (|v[MANT_W_32-1:0]);
   endfunction

endpackage

// File: rtl/arith_fsign_share_if.sv
// rtl/arith_fsign_share_if.sv - requester-side bus bundle for the FP sign-share block
// Purpose: groups the per-requester request/result handshakes.
// Ports:   in_valid/in_ready/in_data/in_op   request channel, one lane per requester
//          out_valid/out_ready/out_data      result channel, shared data bus
//          master modport = requesters, slave modport = arith_fsign_share
interface arith_fsign_share_if #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 32
);
   logic [NUM_REQ-1:0]            in_valid;
   logic [NUM_REQ-1:0]            in_ready;
   logic [NUM_REQ-1:0][WIDTH-1:0] in_data;
   logic [NUM_REQ-1:0][1:0]       in_op;
   logic [NUM_REQ-1:0]            out_valid;
   logic [NUM_REQ-1:0]            out_ready;
   logic [WIDTH-1:0]              out_data;

   modport master (
      output in_valid, in_data, in_op, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, in_op, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/arith_fsign_share_rr_arbiter.sv
// rtl/arith_fsign_share_rr_arbiter.sv - combinational round-robin grant search
// Purpose: picks the first active request at or after ptr_i, wrapping at NUM_REQ-1.
// Ports:   req_i  request vector        ptr_i  search start index
//          en_i   grant enable          gnt_o  one-hot grant
//          idx_o  index of the grant (0 when no grant)
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   ptr_i,
   input  logic               en_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [IDX_W-1:0]   idx_o
);

   logic             found;
   logic [IDX_W-1:0] cand;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      cand  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         // Explicit wrap so non-power-of-two NUM_REQ never indexes past the last lane.
         if (int'(ptr_i) + k >= NUM_REQ) begin
            cand = IDX_W'(int'(ptr_i) + k - NUM_REQ);
         end else begin
            cand = IDX_W'(int'(ptr_i) + k);
         end
         if (en_i && !found && req_i[cand]) begin
            found        = 1'b1;
            gnt_o[cand]  = 1'b1;
            idx_o        = cand;
         end
      end
   end

endmodule

// File: rtl/arith_fsign_share.sv
// rtl/arith_fsign_share.sv - shared negate/abs/pass FP sign unit with round-robin arbitration
// Purpose: one registered result slot shared by NUM_REQ requesters; result routed back to
//          the requester that issued it. Same-cycle drain and refill gives full throughput.
// Ports:   clk  clock
//          rst  asynchronous active-high reset
//          bus  arith_fsign_share_if.slave (request and result channels)
// Config:  ARITH_FSIGN_NAN_CANON_EN - when defined, any NaN operand yields the canonical
//          quiet NaN; otherwise NaNs follow the plain sign-bit rule with payload kept.
module arith_fsign_share
   import arith_fsign_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 32
) (
   input logic              clk,
   input logic              rst,
   arith_fsign_share_if.slave bus
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   if (WIDTH != 32 && WIDTH != 64) begin : g_bad_width
      $fatal(1, "arith_fsign_share: WIDTH must be 32 or 64");
   end
   if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
      $fatal(1, "arith_fsign_share: NUM_REQ must be 2..16");
   end

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } res_state_e;

   res_state_e         state_q, state_d;
   logic [IDX_W-1:0]   owner_q, owner_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [WIDTH-1:0]   data_q, data_d;

   logic [NUM_REQ-1:0] gnt;
   logic [IDX_W-1:0]   gnt_idx;
   logic [WIDTH-1:0]   operand;
   logic [WIDTH-1:0]   op_result;
   fsign_op_e          op;
   logic               res_valid, drain, slot_free, arb_en, accept;
   logic [NUM_REQ-1:0] out_valid_vec;

   assign res_valid = (state_q == ST_FULL);
   assign drain     = res_valid && bus.out_ready[owner_q];
   assign slot_free = !res_valid || drain;
   // Gating with rst keeps every in_ready low while reset is held.
   assign arb_en    = slot_free && !rst;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_arb (
      .req_i (bus.in_valid),
      .ptr_i (ptr_q),
      .en_i  (arb_en),
      .gnt_o (gnt),
      .idx_o (gnt_idx)
   );

   assign bus.in_ready = gnt;
   assign accept       = |(gnt & bus.in_valid);
   assign operand      = bus.in_data[gnt_idx];
   assign op           = fsign_op_e'(bus.in_op[gnt_idx]);

   always_comb begin
      op_result = operand;
      case (op)
         OP_NEG:  op_result[WIDTH-1] = ~operand[WIDTH-1];
         OP_ABS:  op_result[WIDTH-1] = 1'b0;
         default: op_result = operand;   // PASS and reserved
      endcase
`ifdef ARITH_FSIGN_NAN_CANON_EN
      if (is_nan(64'(operand), WIDTH == 64)) begin
         op_result = (WIDTH == 64) ? WIDTH'(CANON_NAN_64) : WIDTH'(CANON_NAN_32);
      end
`endif
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      data_d  = data_q;
      ptr_d   = ptr_q;
      if (accept) begin
         // Refill wins over drain: covers both EMPTY->FULL and same-cycle drain+refill.
         state_d = ST_FULL;
         owner_d = gnt_idx;
         data_d  = op_result;
         ptr_d   = (gnt_idx == IDX_W'(NUM_REQ-1)) ? '0 : gnt_idx + IDX_W'(1);
      end else if (drain) begin
         state_d = ST_EMPTY;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_EMPTY;
         owner_q <= '0;
         ptr_q   <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         data_q  <= data_d;
      end
   end

   always_comb begin
      out_valid_vec = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         out_valid_vec[i] = res_valid && (owner_q == IDX_W'(i));
      end
   end

   assign bus.out_valid = out_valid_vec;
   assign bus.out_data  = data_q;

endmodule

// File: tb/tb_arith_fsign_share.sv
// tb/tb_arith_fsign_share.sv - self-checking bench for arith_fsign_share
module tb_arith_fsign_share;

   localparam int N = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   arith_fsign_share_if #(.NUM_REQ(N), .WIDTH(32)) bus32();
   arith_fsign_share_if #(.NUM_REQ(N), .WIDTH(64)) bus64();

   arith_fsign_share #(.NUM_REQ(N), .WIDTH(32)) dut32 (
      .clk (clk),
      .rst (rst),
      .bus (bus32)
   );

   arith_fsign_share #(.NUM_REQ(N), .WIDTH(64)) dut64 (
      .clk (clk),
      .rst (rst),
      .bus (bus64)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference operation on a 32-bit operand, expressed as plain bit arithmetic.
   function automatic logic [31:0] ref_op(input logic [1:0] op, input logic [31:0] d);
`ifdef ARITH_FSIGN_NAN_CANON_EN
      if (d[30:23] == 8'hFF && d[22:0] != 23'd0) return 32'h7FC0_0000;
`endif
      case (op)
         2'b00:   return d ^ 32'h8000_0000;
         2'b01:   return d & 32'h7FFF_FFFF;
         default: return d;
      endcase
   endfunction

   // Abstract model of the 32-bit instance: one slot, owner, data, priority pointer.
   logic        m_valid = 1'b0;
   int          m_owner = 0;
   logic [31:0] m_data  = '0;
   int          m_ptr   = 0;

   function automatic int m_grant();
      int i;
      if (rst) return -1;
      if (m_valid && !bus32.out_ready[m_owner]) return -1;
      for (int k = 0; k < N; k++) begin
         i = (m_ptr + k) % N;
         if (bus32.in_valid[i]) return i;
      end
      return -1;
   endfunction

   int upd_g;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_valid = 1'b0;
         m_owner = 0;
         m_data  = '0;
         m_ptr   = 0;
      end else begin
         upd_g = m_grant();
         if (m_valid && bus32.out_ready[m_owner]) m_valid = 1'b0;
         if (upd_g >= 0) begin
            m_valid = 1'b1;
            m_owner = upd_g;
            m_data  = ref_op(bus32.in_op[upd_g], bus32.in_data[upd_g]);
            m_ptr   = (upd_g + 1) % N;
         end
      end
   end

   int       cmp_g;
   logic [3:0] exp_rdy, exp_ov;
   always @(negedge clk) begin
      cmp_g   = m_grant();
      exp_rdy = '0;
      if (cmp_g >= 0) exp_rdy[cmp_g] = 1'b1;
      exp_ov  = m_valid ? 4'(1 << m_owner) : 4'b0000;
      check("model in_ready", 64'(bus32.in_ready), 64'(exp_rdy));
      check("model out_valid", 64'(bus32.out_valid), 64'(exp_ov));
      if (m_valid) check("model out_data", 64'(bus32.out_data), 64'(m_data));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [3:0]  rr_exp [5];
   logic [31:0] rr_dat [4];

   initial begin
      rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      rr_dat = '{32'hC000_0000, 32'h4000_0000, 32'hFF80_0000, 32'h8000_0000};

      bus32.in_valid  = 4'b1111;
      bus32.in_data   = '0;
      bus32.in_op     = '0;
      bus32.out_ready = '0;
      bus64.in_valid  = '0;
      bus64.in_data   = '0;
      bus64.in_op     = '0;
      bus64.out_ready = '1;

      // Reset state, with requests pending
      repeat (2) begin
         @(negedge clk);
         check("reset in_ready", 64'(bus32.in_ready), 64'h0);
         check("reset out_valid", 64'(bus32.out_valid), 64'h0);
         check("reset out_data", 64'(bus32.out_data), 64'h0);
      end
      tick();
      rst             = 1'b0;
      bus32.in_valid  = '0;
      bus32.out_ready = '1;

      // Single request: requester 1 NEG 1.0
      bus32.in_valid[1] = 1'b1;
      bus32.in_data[1]  = 32'h3F80_0000;
      bus32.in_op[1]    = 2'b00;
      @(negedge clk);
      check("single in_ready", 64'(bus32.in_ready), 64'h2);
      tick();
      bus32.in_valid = '0;
      @(negedge clk);
      check("single out_valid", 64'(bus32.out_valid), 64'h2);
      check("single out_data", 64'(bus32.out_data), 64'hBF80_0000);

      // Requester 3 PASS moves the pointer back to 0
      tick();
      bus32.in_valid   = 4'b1000;
      bus32.in_data[3] = 32'h1234_5678;
      bus32.in_op[3]   = 2'b10;
      tick();

      // Round robin with all four requesters active
      bus32.in_valid = 4'b1111;
      bus32.in_data  = {32'h8000_0000, 32'h7F80_0000, 32'hC000_0000, 32'h4000_0000};
      bus32.in_op    = {2'b11, 2'b00, 2'b01, 2'b00};
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("rr grant", 64'(bus32.in_ready), 64'(rr_exp[k]));
         if (k > 0) begin
            check("rr out_valid", 64'(bus32.out_valid), 64'(rr_exp[k-1]));
            check("rr out_data", 64'(bus32.out_data), 64'(rr_dat[k-1]));
         end
         tick();
      end
      bus32.in_valid = '0;
      @(negedge clk);
      check("rr wrap out_valid", 64'(bus32.out_valid), 64'h1);
      check("rr wrap out_data", 64'(bus32.out_data), 64'hC000_0000);

      // Backpressure: owner 0 stalls while requester 1 waits
      tick();
      bus32.in_valid   = 4'b0001;
      bus32.in_data[0] = 32'hC049_0FDB;
      bus32.in_op[0]   = 2'b01;
      bus32.out_ready  = 4'b1110;
      @(negedge clk);
      check("bp first grant", 64'(bus32.in_ready), 64'h1);
      tick();
      bus32.in_valid   = 4'b0010;
      bus32.in_data[1] = 32'h0000_0000;
      bus32.in_op[1]   = 2'b00;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("bp in_ready stalled", 64'(bus32.in_ready), 64'h0);
         check("bp out_valid held", 64'(bus32.out_valid), 64'h1);
         tick();
      end
      bus32.out_ready = 4'b1111;
      @(negedge clk);
      check("bp same-cycle accept", 64'(bus32.in_ready), 64'h2);
      check("bp held data", 64'(bus32.out_data), 64'h4049_0FDB);
      tick();
      bus32.in_valid = '0;
      @(negedge clk);
      check("bp follow out_valid", 64'(bus32.out_valid), 64'h2);
      check("bp follow out_data", 64'(bus32.out_data), 64'h8000_0000);

      // NaN and infinity
      tick();
      bus32.in_valid   = 4'b0100;
      bus32.in_data[2] = 32'h7FA0_0001;
      bus32.in_op[2]   = 2'b00;
      tick();
      bus32.in_valid = '0;
      @(negedge clk);
`ifdef ARITH_FSIGN_NAN_CANON_EN
      check("nan neg", 64'(bus32.out_data), 64'h7FC0_0000);
`else
      check("nan neg", 64'(bus32.out_data), 64'hFFA0_0001);
`endif
      tick();
      bus32.in_valid   = 4'b0001;
      bus32.in_data[0] = 32'hFF80_0000;
      bus32.in_op[0]   = 2'b01;
      tick();
      bus32.in_valid = '0;
      @(negedge clk);
      check("abs -inf", 64'(bus32.out_data), 64'h7F80_0000);
      tick();

      // Reset while a result is held
      bus32.in_valid   = 4'b0001;
      bus32.in_data[0] = 32'h3F80_0000;
      bus32.in_op[0]   = 2'b00;
      bus32.out_ready  = 4'b0000;
      tick();
      bus32.in_valid = '0;
      #2;
      check("rm held before reset", 64'(bus32.out_valid), 64'h1);
      rst = 1'b1;
      #1;
      check("rm async out_valid", 64'(bus32.out_valid), 64'h0);
      check("rm async out_data", 64'(bus32.out_data), 64'h0);
      check("rm async in_ready", 64'(bus32.in_ready), 64'h0);
      tick();
      rst             = 1'b0;
      bus32.out_ready = 4'b1111;
      repeat (3) begin
         @(negedge clk);
         check("rm no result after release", 64'(bus32.out_valid), 64'h0);
      end

      // 64-bit instance: ABS then PASS on the same operand
      tick();
      bus64.in_valid   = 4'b0100;
      bus64.in_data[2] = 64'hC000_0000_0000_0000;
      bus64.in_op[2]   = 2'b01;
      @(negedge clk);
      check("w64 in_ready", 64'(bus64.in_ready), 64'h4);
      tick();
      bus64.in_op[2] = 2'b10;
      @(negedge clk);
      check("w64 abs out_valid", 64'(bus64.out_valid), 64'h4);
      check("w64 abs out_data", bus64.out_data, 64'h4000_0000_0000_0000);
      tick();
      bus64.in_valid = '0;
      @(negedge clk);
      check("w64 pass out_data", bus64.out_data, 64'hC000_0000_0000_0000);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
